// File: rtl/hazard_scoreboard.sv
// Register and XALU hazard scoreboard for the decode stage: per-register countdowns
// of cycles until a result is forwardable, plus a busy counter for the multi-cycle XALU.
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int NSRC    = 2,
  parameter int TW      = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  localparam int RW     = $clog2(NREG),
  localparam int XMAX   = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT,
  localparam int XW     = $clog2(XMAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [NSRC-1:0]      src_need,
  input  logic [NSRC*RW-1:0]   src_reg,
  input  logic [NSRC*TW-1:0]   src_tuse,
  input  logic                 dst_we,
  input  logic [RW-1:0]        dst_reg,
  input  logic [TW-1:0]        dst_tnew,
  input  logic                 xalu_op,
  input  logic                 xalu_start,
  input  logic                 xalu_is_div,
  input  logic                 hold,
  input  logic                 flush,
  output logic                 stall,
  output logic                 issue_fire,
  output logic                 xalu_busy,
  output logic [NREG-1:0]      pending
);

  logic [TW-1:0] cnt [NREG];
  logic [XW-1:0] xcnt;

  logic [RW-1:0] src_idx [NSRC];
  logic [TW-1:0] src_t   [NSRC];
  logic [NSRC-1:0] stall_src;
  logic stall_x;
  logic load_en;
  logic xload_en;

  // Hazard checks use the counts before this cycle's load, so an instruction
  // reading its own destination sees the older producer only.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign src_idx[g]   = src_reg[g*RW +: RW];
    assign src_t[g]     = src_tuse[g*TW +: TW];
    assign stall_src[g] = src_need[g] && (src_idx[g] != '0) && (cnt[src_idx[g]] > src_t[g]);
  end

  assign stall_x    = xalu_op && (xcnt != '0);
  assign stall      = issue_valid && !flush && ((|stall_src) || stall_x || hold);
  assign issue_fire = issue_valid && !flush && !stall;
  assign load_en    = issue_fire && dst_we && (dst_reg != '0);
  assign xload_en   = issue_fire && xalu_start;

  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    for (int r = 1; r < NREG; r++) begin
      if (reset || flush) begin
        cnt[r] <= '0;
      end else if (load_en && (dst_reg == RW'(r))) begin
        cnt[r] <= dst_tnew;
      end else if (!hold && (cnt[r] != '0)) begin
        cnt[r] <= cnt[r] - TW'(1);
      end
    end
  end

  // The XALU keeps counting through hold and flush: an operation in flight always completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      xcnt <= '0;
    end else if (xload_en) begin
      xcnt <= xalu_is_div ? XW'(DIV_LAT) : XW'(MUL_LAT);
    end else if (xcnt != '0) begin
      xcnt <= xcnt - XW'(1);
    end
  end

  assign xalu_busy = (xcnt != '0);

  always_comb begin
    pending = '0;
    for (int r = 1; r < NREG; r++) begin
      pending[r] = (cnt[r] != '0);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: constant vector table, directed multi-cycle sequences,
// and random traffic, all checked against an integer-array scoreboard model.
module tb_hazard_scoreboard;

  localparam int NREG    = 32;
  localparam int NSRC    = 2;
  localparam int TW      = 3;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;
  localparam int RW      = $clog2(NREG);

  logic               clk = 1'b0;
  logic               reset;
  logic               issue_valid;
  logic [NSRC-1:0]    src_need;
  logic [NSRC*RW-1:0] src_reg;
  logic [NSRC*TW-1:0] src_tuse;
  logic               dst_we;
  logic [RW-1:0]      dst_reg;
  logic [TW-1:0]      dst_tnew;
  logic               xalu_op, xalu_start, xalu_is_div, hold, flush;
  logic               stall, issue_fire, xalu_busy;
  logic [NREG-1:0]    pending;

  hazard_scoreboard #(.NREG(NREG), .NSRC(NSRC), .TW(TW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .src_need(src_need),
    .src_reg(src_reg), .src_tuse(src_tuse), .dst_we(dst_we), .dst_reg(dst_reg),
    .dst_tnew(dst_tnew), .xalu_op(xalu_op), .xalu_start(xalu_start),
    .xalu_is_div(xalu_is_div), .hold(hold), .flush(flush), .stall(stall),
    .issue_fire(issue_fire), .xalu_busy(xalu_busy), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, valid;
    bit [1:0] need;
    int       s0, t0, s1, t1;
    bit       we;
    int       d, tn;
    bit       xop, xs, xd, hd, fl;
  } vec_t;

  typedef struct {
    vec_t v;
    bit   e_stall, e_fire;
  } row_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: remaining cycles per register and for the XALU.
  int mcnt [NREG];
  int mx;

  bit              s_stall, s_fire, s_busy;
  logic [NREG-1:0] s_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit valid, input bit [1:0] need, input int s0, t0, s1, t1,
                              input bit we, input int d, tn, input bit xop, xs, xd, hd, fl);
    vec_t v;
    v.rst = 1'b0; v.valid = valid; v.need = need;
    v.s0 = s0; v.t0 = t0; v.s1 = s1; v.t1 = t1;
    v.we = we; v.d = d; v.tn = tn;
    v.xop = xop; v.xs = xs; v.xd = xd; v.hd = hd; v.fl = fl;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic model_eval(input vec_t v, output bit e_stall, output bit e_fire,
                            output logic [NREG-1:0] e_pend, output bit e_busy);
    bit hz;
    int sr [2];
    int tu [2];
    sr[0] = v.s0; sr[1] = v.s1; tu[0] = v.t0; tu[1] = v.t1;
    hz = 0;
    for (int i = 0; i < 2; i++)
      if (v.need[i] && sr[i] != 0 && mcnt[sr[i]] > tu[i]) hz = 1;
    e_stall = v.valid && !v.fl && (hz || (v.xop && mx > 0) || v.hd);
    e_fire  = v.valid && !v.fl && !e_stall;
    e_pend  = '0;
    for (int r = 1; r < NREG; r++) e_pend[r] = (mcnt[r] > 0);
    e_busy = (mx > 0);
  endtask

  task automatic model_update(input vec_t v, input bit fire);
    if (v.rst) begin
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
      mx = 0;
    end else begin
      if (v.fl) begin
        for (int r = 0; r < NREG; r++) mcnt[r] = 0;
      end else begin
        if (!v.hd)
          for (int r = 1; r < NREG; r++) if (mcnt[r] > 0) mcnt[r]--;
        if (fire && v.we && v.d != 0) mcnt[v.d] = v.tn;
      end
      if (fire && v.xs) mx = v.xd ? DIV_LAT : MUL_LAT;
      else if (mx > 0) mx--;
    end
  endtask

  task automatic apply(input vec_t v, input bit do_chk);
    bit e_stall, e_fire, e_busy;
    logic [NREG-1:0] e_pend;
    reset       = v.rst;
    issue_valid = v.valid;
    src_need    = v.need;
    src_reg     = {RW'(v.s1), RW'(v.s0)};
    src_tuse    = {TW'(v.t1), TW'(v.t0)};
    dst_we      = v.we;
    dst_reg     = RW'(v.d);
    dst_tnew    = TW'(v.tn);
    xalu_op     = v.xop;
    xalu_start  = v.xs;
    xalu_is_div = v.xd;
    hold        = v.hd;
    flush       = v.fl;
    #1;
    model_eval(v, e_stall, e_fire, e_pend, e_busy);
    s_stall = stall; s_fire = issue_fire; s_busy = xalu_busy; s_pend = pending;
    if (do_chk) begin
      chk("stall", 64'(stall), 64'(e_stall));
      chk("issue_fire", 64'(issue_fire), 64'(e_fire));
      chk("xalu_busy", 64'(xalu_busy), 64'(e_busy));
      chk("pending", 64'(pending), 64'(e_pend));
    end
    @(posedge clk);
    model_update(v, e_fire);
    @(negedge clk);
  endtask

  // Repeats one instruction until it issues; n = cycles spent stalled.
  task automatic count_stalls(input vec_t v, input int limit, output int n, output bit fired);
    n = 0;
    fired = 0;
    for (int k = 0; k < limit; k++) begin
      apply(v, 1);
      if (s_fire) begin
        fired = 1;
        break;
      end
      n++;
    end
  endtask

  row_t rows [16];

  initial begin
    vec_t v, mflo, rv;
    int n;
    bit fired;

    rows[0]  = '{mk(1, 2'b00, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0, 0), 0, 1};
    rows[1]  = '{mk(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0};
    rows[2]  = rows[1];
    rows[3]  = '{rows[1].v, 0, 1};
    rows[4]  = rows[0];
    rows[5]  = '{mk(1, 2'b01, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0};
    rows[6]  = '{rows[5].v, 0, 1};
    rows[7]  = '{mk(1, 2'b00, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0), 0, 1};
    rows[8]  = '{mk(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1};
    rows[9]  = '{mk(1, 2'b00, 0, 0, 0, 0, 1, 4, 3, 0, 0, 0, 0, 0), 0, 1};
    rows[10] = '{mk(1, 2'b00, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0), 0, 1};
    rows[11] = '{mk(1, 2'b10, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0};
    rows[12] = '{rows[11].v, 0, 1};
    rows[13] = '{mk(1, 2'b01, 6, 0, 0, 0, 1, 6, 3, 0, 0, 0, 0, 0), 0, 1};
    rows[14] = '{mk(1, 2'b01, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0};
    rows[15] = '{rows[14].v, 0, 1};

    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    mx = 0;

    v = idle(); v.rst = 1;
    apply(v, 0);
    v = mk(1, 2'b11, 3, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0); v.rst = 1;
    apply(v, 1);
    chk("reset_fire", 64'(s_fire), 64'(1));
    chk("reset_pending", 64'(s_pend), 64'(0));
    v = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); v.rst = 1;
    apply(v, 1);
    chk("reset_hold_stall", 64'(s_stall), 64'(1));

    for (int k = 0; k < 16; k++) begin
      apply(rows[k].v, 1);
      chk($sformatf("tbl_stall[%0d]", k), 64'(s_stall), 64'(rows[k].e_stall));
      chk($sformatf("tbl_fire[%0d]", k), 64'(s_fire), 64'(rows[k].e_fire));
      if (k == 8) chk("tbl_pending0", 64'(s_pend[0]), 64'(0));
    end
    repeat (8) apply(idle(), 1);

    // Producer to r7, then two held cycles before the consumer may proceed.
    apply(mk(1, 2'b00, 0, 0, 0, 0, 1, 7, 3, 0, 0, 0, 0, 0), 1);
    repeat (2) begin
      apply(mk(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1);
      chk("hold_stall", 64'(s_stall), 64'(1));
      chk("hold_pending7", 64'(s_pend[7]), 64'(1));
    end
    count_stalls(mk(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10, n, fired);
    chk("hold_release_fired", 64'(fired), 64'(1));
    chk("hold_release_stalls", 64'(n), 64'(3));

    mflo = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1);
    count_stalls(mflo, 10, n, fired);
    chk("mul_fired", 64'(fired), 64'(1));
    chk("mul_stalls", 64'(n), 64'(MUL_LAT));
    chk("mul_busy_at_fire", 64'(s_busy), 64'(0));

    apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), 1);
    count_stalls(mflo, 40, n, fired);
    chk("div_fired", 64'(fired), 64'(1));
    chk("div_stalls", 64'(n), 64'(DIV_LAT));
    chk("div_busy_at_fire", 64'(s_busy), 64'(0));

    // A non-XALU add issued right behind a divide takes one cycle off the mflo wait.
    apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), 1);
    apply(mk(1, 2'b11, 1, 0, 2, 0, 1, 3, 1, 0, 0, 0, 0, 0), 1);
    chk("add_during_div_fire", 64'(s_fire), 64'(1));
    chk("add_during_div_busy", 64'(s_busy), 64'(1));
    count_stalls(mflo, 40, n, fired);
    chk("div_after_add_fired", 64'(fired), 64'(1));
    chk("div_after_add_stalls", 64'(n), 64'(DIV_LAT - 1));

    apply(mk(1, 2'b00, 0, 0, 0, 0, 1, 9, 3, 1, 1, 0, 0, 0), 1);
    apply(mk(1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    chk("flush_stall", 64'(s_stall), 64'(0));
    chk("flush_fire", 64'(s_fire), 64'(0));
    chk("flush_pending9_before", 64'(s_pend[9]), 64'(1));
    apply(idle(), 1);
    chk("flush_pending_after", 64'(s_pend), 64'(0));
    chk("flush_busy_kept", 64'(s_busy), 64'(1));
    repeat (6) apply(idle(), 1);

    apply(mk(1, 2'b00, 0, 0, 0, 0, 1, 12, 2, 1, 1, 1, 0, 0), 1);
    v = idle(); v.rst = 1;
    apply(v, 1);
    chk("mid_div_busy_before_reset", 64'(s_busy), 64'(1));
    apply(mk(1, 2'b01, 12, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1);
    chk("post_reset_mflo_fire", 64'(s_fire), 64'(1));
    chk("post_reset_busy", 64'(s_busy), 64'(0));
    chk("post_reset_pending", 64'(s_pend), 64'(0));

    for (int k = 0; k < 3000; k++) begin
      rv.rst   = ($urandom_range(0, 199) == 0);
      rv.valid = ($urandom_range(0, 9) != 0);
      rv.need  = 2'($urandom_range(0, 3));
      rv.s0    = $urandom_range(0, 7);
      rv.t0    = $urandom_range(0, 7);
      rv.s1    = $urandom_range(0, 7);
      rv.t1    = $urandom_range(0, 7);
      rv.we    = ($urandom_range(0, 1) == 1);
      rv.d     = $urandom_range(0, 7);
      rv.tn    = $urandom_range(0, 7);
      rv.xop   = ($urandom_range(0, 3) == 0);
      rv.xs    = rv.xop && ($urandom_range(0, 1) == 1);
      rv.xd    = ($urandom_range(0, 3) == 0);
      rv.hd    = ($urandom_range(0, 9) == 0);
      rv.fl    = ($urandom_range(0, 19) == 0);
      apply(rv, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
